apa102_line_tx: RTL

Parametrised SPI line transmitter for APA102-class serial LED strips. It streams one complete refresh of up to MAX_PIXELS pixels from an external pixel store: a start frame, one 32-bit frame per pixel, and an end frame. It generates its own SPI clock from the system clock and fetches pixels through an address/data port. It replaces the fixed-divider pair of clock generator and line transmitter in the LED controller datapath.

---
 rtl/apa102_pkg.sv | 27 ++
 rtl/apa102_sclk_gen.sv | 50 +++++
 rtl/apa102_line_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/apa102_pkg.sv
// Shared definitions for the APA102 line transmitter.
//   state_e    : line FSM states
//   START_WORD : 32-bit start frame (all zeros)
//   END_WORD   : 32-bit end frame word (all ones)
//   HEADER     : 3-bit marker at the top of every pixel word
//   end_words(): number of end-frame words needed for an n-pixel line
package apa102_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStartFrm,
        StPixel,
        StEndFrm,
        StDone
    } state_e;

    localparam logic [31:0] START_WORD = 32'h0000_0000;
    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [2:0]  HEADER     = 3'b111;

    // One extra clock edge per pixel is needed to push data down the strip,
    // so long lines need additional end-frame words.
    function automatic int unsigned end_words(input int unsigned n);
        return 1 + n / 64;
    endfunction

endpackage

// File: rtl/apa102_sclk_gen.sv
// SPI clock divider for the APA102 line transmitter.
// Ports:
//   clk, rst : system clock, asynchronous active-low reset
//   en_i     : run the divider; when low sclk is forced low and the counter cleared
//   sclk_o   : SPI clock level (CLK_HALF system clocks per half-period)
//   rise_o   : sclk_o goes high at the next clock edge
//   fall_o   : sclk_o goes low at the next clock edge
module apa102_sclk_gen #(
    parameter int unsigned CLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    always_comb begin
        wrap   = en_i && (cnt_q == LAST);
        rise_o = wrap && !sclk_q;
        fall_o = wrap && sclk_q;
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (en_i) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/apa102_line_tx.sv
// APA102 line transmitter: streams one refresh (start frame, n pixel words,
// 1 + n/64 end-frame words) over SPI, fetching pixels by address.
// Ports:
//   clk, rst    : system clock, asynchronous active-low reset
//   start       : one-cycle refresh request, ignored while busy
//   pixel_count : pixels in the refresh (clamped to MAX_PIXELS), sampled on start
//   brightness  : global 5-bit brightness, sampled on start
//   address     : index of the next pixel to load
//   pixel       : {B,G,R} for address, sampled when the word loads
//   sclk, sdo   : SPI clock (idles low) and data, MSB first
//   busy        : refresh in progress (including the done cycle)
//   done        : one-cycle completion pulse
// Build option: APA102_GLOBAL_BRIGHTNESS_EN -- when defined the brightness port
// drives bits 28:24 of each pixel word; otherwise those bits are 5'b11111.
module apa102_line_tx #(
    parameter int unsigned CLK_HALF   = 2,
    parameter int unsigned MAX_PIXELS = 32,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   pixel_count,
    input  logic [4:0]        brightness,
    output logic [ADDR_W-1:0] address,
    input  logic [23:0]       pixel,
    output logic              sclk,
    output logic              sdo,
    output logic              busy,
    output logic              done
);

    import apa102_pkg::*;

    localparam int unsigned     MAX_E    = end_words(MAX_PIXELS);
    localparam int unsigned     WCNT_W   = $clog2(MAX_PIXELS + MAX_E + 1);
    localparam logic [ADDR_W:0] MAX_N    = (ADDR_W + 1)'(MAX_PIXELS);
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [31:0]       shreg_q, shreg_d;
    logic [4:0]        bit_q, bit_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, e_last;
    logic [4:0]        bri;
    logic [31:0]       pixel_word;
    logic              shift_en, sclk_fall, word_end;
    logic              unused_sclk_rise;

`ifdef APA102_GLOBAL_BRIGHTNESS_EN
    logic [4:0] bri_q, bri_d;
    assign bri = bri_q;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign bri = 5'b11111;
`endif

    assign shift_en = (state_q == StStartFrm) || (state_q == StPixel) || (state_q == StEndFrm);

    apa102_sclk_gen #(
        .CLK_HALF(CLK_HALF)
    ) u_sclk_gen (
        .clk   (clk),
        .rst   (rst),
        .en_i  (shift_en),
        .sclk_o(sclk),
        .rise_o(unused_sclk_rise),
        .fall_o(sclk_fall)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        wcnt_d  = wcnt_q;
`ifdef APA102_GLOBAL_BRIGHTNESS_EN
        bri_d   = bri_q;
`endif
        pixel_word = {HEADER, bri, pixel};
        word_end   = sclk_fall && (bit_q == 5'd31);
        e_last     = WCNT_W'(end_words(32'(n_q)) - 1);
        // Saturate rather than wrap when MAX_PIXELS fills the address space.
        addr_inc   = (addr_q == ADDR_TOP) ? addr_q : addr_q + 1'b1;

        // sdo advances on the edge where sclk falls; word loads below override.
        if (sclk_fall) begin
            shreg_d = {shreg_q[30:0], 1'b0};
            bit_d   = bit_q + 5'd1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = (pixel_count > MAX_N) ? MAX_N : pixel_count;
`ifdef APA102_GLOBAL_BRIGHTNESS_EN
                    bri_d   = brightness;
`endif
                    addr_d  = '0;
                    shreg_d = START_WORD;
                    bit_d   = '0;
                    wcnt_d  = '0;
                    state_d = StStartFrm;
                end
            end
            StStartFrm: begin
                if (word_end) begin
                    if (n_q == '0) begin
                        shreg_d = END_WORD;
                        wcnt_d  = e_last;
                        state_d = StEndFrm;
                    end else begin
                        shreg_d = pixel_word;
                        addr_d  = addr_inc;
                        wcnt_d  = WCNT_W'(n_q - 1'b1);
                        state_d = StPixel;
                    end
                end
            end
            StPixel: begin
                // wcnt_q holds the pixel words still to load after the current one.
                if (word_end) begin
                    if (wcnt_q == '0) begin
                        shreg_d = END_WORD;
                        wcnt_d  = e_last;
                        state_d = StEndFrm;
                    end else begin
                        shreg_d = pixel_word;
                        addr_d  = addr_inc;
                        wcnt_d  = wcnt_q - 1'b1;
                    end
                end
            end
            StEndFrm: begin
                if (word_end) begin
                    if (wcnt_q == '0) begin
                        shreg_d = '0;
                        state_d = StDone;
                    end else begin
                        shreg_d = END_WORD;
                        wcnt_d  = wcnt_q - 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            addr_q  <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
            wcnt_q  <= '0;
`ifdef APA102_GLOBAL_BRIGHTNESS_EN
            bri_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            wcnt_q  <= wcnt_d;
`ifdef APA102_GLOBAL_BRIGHTNESS_EN
            bri_q   <= bri_d;
`endif
        end
    end

    assign address = addr_q;
    assign sdo     = shreg_q[31];
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);

endmodule
